// File: rtl/selevy_runctl_pkg.sv
// Shared definitions for the selevy run controller: FSM state encodings and
// the default widths of the trace entry fields {timestamp, gout}.
package selevy_runctl_pkg;

    typedef enum logic [2:0] {
        RC_IDLE     = 3'd0,
        RC_RST_HOLD = 3'd1,
        RC_RUN      = 3'd2,
        RC_CHECK    = 3'd3,
        RC_DONE     = 3'd4
    } rc_state_t;

    localparam int RC_STATE_W = 3;
    localparam int DEF_GOUT_W = 4;
    localparam int DEF_CNT_W  = 16;

    function automatic int trace_entry_w(input int cnt_w, input int gout_w);
        return cnt_w + gout_w;
    endfunction

endpackage

// File: rtl/selevy_trace_buf.sv
// Circular trace buffer: keeps the newest DEPTH entries and reads them back
// by index relative to the oldest valid entry.
module selevy_trace_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       we,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   ridx,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] raddr;

    // DEPTH is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (clear) begin
            wptr  <= '0;
            count <= '0;
        end else if (we) begin
            wptr <= wptr + IDX_W'(1);
            if (count != FULL_CNT) begin
                count <= count + (IDX_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we && !clear) begin
            mem[wptr] <= wdata;
        end
    end

    // Once full, the slot about to be overwritten is the oldest entry.
    assign base  = (count == FULL_CNT) ? wptr : '0;
    assign raddr = base + ridx;
    assign rdata = ({1'b0, ridx} < count) ? mem[raddr] : '0;

endmodule

// File: rtl/selevy_runctl.sv
// Run controller for the selevy core: reset hold, timed or free run, gout
// change tracing, and a final compare of gout against the expected value.
module selevy_runctl
    import selevy_runctl_pkg::*;
#(
    parameter int GOUT_W     = DEF_GOUT_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 21,
    parameter int HIST_DEPTH = 8
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    input  logic [GOUT_W-1:0]               gout,
    input  logic [GOUT_W-1:0]               expect_gout,
    output logic                            core_reset,
    output logic                            core_en,
    output logic [RC_STATE_W-1:0]           state,
    output logic [CNT_W-1:0]                cycle_cnt,
    output logic                            done,
    output logic                            pass,
    output logic [$clog2(HIST_DEPTH):0]     trace_cnt,
    input  logic [$clog2(HIST_DEPTH)-1:0]   trace_idx,
    output logic [CNT_W+GOUT_W-1:0]         trace_data
);

    localparam int ENTRY_W = trace_entry_w(CNT_W, GOUT_W);
    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

    rc_state_t          state_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GOUT_W-1:0]  prev_gout;
    logic               start_seq;
    logic               run_exit;
    logic               trace_we;
    logic               trace_clear;

    assign state     = state_q;
    assign start_seq = start && ((state_q == RC_IDLE) || (state_q == RC_DONE));
    assign run_exit  = stop || ((RUN_CYCLES != 0) && (cycle_cnt == RUN_LAST));

    // The first RUN cycle (cycle_cnt==0) only seeds prev_gout, so it never logs.
    assign trace_we    = (state_q == RC_RUN) && (cycle_cnt != '0) && (gout != prev_gout);
    assign trace_clear = reset || start_seq;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= RC_IDLE;
            core_reset <= 1'b1;
            core_en    <= 1'b0;
            cycle_cnt  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            hold_cnt   <= '0;
            prev_gout  <= '0;
        end else begin
            case (state_q)
                RC_IDLE, RC_DONE: begin
                    if (start) begin
                        state_q    <= RC_RST_HOLD;
                        core_reset <= 1'b1;
                        core_en    <= 1'b0;
                        hold_cnt   <= '0;
                        cycle_cnt  <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                RC_RST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_q    <= RC_RUN;
                        core_reset <= 1'b0;
                        core_en    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RC_RUN: begin
                    prev_gout <= gout;
                    if (run_exit) begin
                        state_q <= RC_CHECK;
                        core_en <= 1'b0;
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                RC_CHECK: begin
                    pass    <= (gout == expect_gout);
                    done    <= 1'b1;
                    state_q <= RC_DONE;
                end
                default: begin
                    state_q    <= RC_IDLE;
                    core_reset <= 1'b1;
                    core_en    <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    selevy_trace_buf #(
        .DEPTH (HIST_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace (
        .clk   (CLK),
        .clear (trace_clear),
        .we    (trace_we),
        .wdata ({cycle_cnt, gout}),
        .ridx  (trace_idx),
        .count (trace_cnt),
        .rdata (trace_data)
    );

endmodule

// File: tb/tb_selevy_runctl.sv
// Bench for selevy_runctl: a default instance (timed run, depth 8) and a
// free-running depth-4 instance, checked through an expected-value queue.
module tb_selevy_runctl;
    import selevy_runctl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b1, start_a = 1'b0, stop_a = 1'b0;
    logic [3:0]  gout_a = '0, expect_a = '0;
    logic        core_reset_a, core_en_a, done_a, pass_a;
    logic [2:0]  state_a;
    logic [15:0] cycle_cnt_a;
    logic [3:0]  trace_cnt_a;
    logic [2:0]  trace_idx_a = '0;
    logic [19:0] trace_data_a;

    logic        reset_b = 1'b1, start_b = 1'b0, stop_b = 1'b0;
    logic [3:0]  gout_b = '0, expect_b = '0;
    logic        core_reset_b, core_en_b, done_b, pass_b;
    logic [2:0]  state_b;
    logic [15:0] cycle_cnt_b;
    logic [2:0]  trace_cnt_b;
    logic [1:0]  trace_idx_b = '0;
    logic [19:0] trace_data_b;

    selevy_runctl dut_a (
        .CLK(clk), .reset(reset_a), .start(start_a), .stop(stop_a),
        .gout(gout_a), .expect_gout(expect_a), .core_reset(core_reset_a),
        .core_en(core_en_a), .state(state_a), .cycle_cnt(cycle_cnt_a),
        .done(done_a), .pass(pass_a), .trace_cnt(trace_cnt_a),
        .trace_idx(trace_idx_a), .trace_data(trace_data_a)
    );

    selevy_runctl #(.HIST_DEPTH(4), .RUN_CYCLES(0)) dut_b (
        .CLK(clk), .reset(reset_b), .start(start_b), .stop(stop_b),
        .gout(gout_b), .expect_gout(expect_b), .core_reset(core_reset_b),
        .core_en(core_en_b), .state(state_b), .cycle_cnt(cycle_cnt_b),
        .done(done_b), .pass(pass_b), .trace_cnt(trace_cnt_b),
        .trace_idx(trace_idx_b), .trace_data(trace_data_b)
    );

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        logic [31:0] e;
        string t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("[TB] FAIL unqueued: observed %0h, no expected value queued", observed);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (observed === e) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", t, observed, e);
        end
    endtask

    task automatic applyStimulus(input bit sel_b, input logic [3:0] expv);
        if (sel_b) begin
            expect_b = expv;
            gout_b   = '0;
            start_b  = 1'b1;
        end else begin
            expect_a = expv;
            gout_a   = '0;
            start_a  = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // gout steps 0 -> 1 at run cycle 5 -> 3 at run cycle 9.
    task automatic runA(input logic [3:0] expv);
        int rst_len = 0;
        int run_len = 0;
        int chk_len = 0;
        int cnt_err = 0;
        expectVal("a_start_state", 32'd1);
        expectVal("a_start_pass", 32'd0);
        expectVal("a_start_cycle", 32'd0);
        expectVal("a_start_trace", 32'd0);
        expectVal("a_start_done", 32'd0);
        expectVal("a_rst_len", 32'd2);
        expectVal("a_run_len", 32'd21);
        expectVal("a_chk_len", 32'd1);
        expectVal("a_cnt_track_err", 32'd0);
        expectVal("a_cycle_cnt", 32'd20);
        expectVal("a_done", 32'd1);
        expectVal("a_pass", (expv == 4'd3) ? 32'd1 : 32'd0);
        expectVal("a_trace_cnt", 32'd2);
        expectVal("a_trace0", 32'h00051);
        expectVal("a_trace1", 32'h00093);
        expectVal("a_trace5_oob", 32'd0);
        applyStimulus(1'b0, expv);
        checkOutput(32'(state_a));
        checkOutput(32'(pass_a));
        checkOutput(32'(cycle_cnt_a));
        checkOutput(32'(trace_cnt_a));
        checkOutput(32'(done_a));
        for (int guard = 0; guard < 100 && !done_a; guard++) begin
            if (state_a == 3'd1 && core_reset_a && !core_en_a) rst_len++;
            if (state_a == 3'd2 && core_en_a && !core_reset_a) begin
                if (32'(cycle_cnt_a) != run_len) cnt_err++;
                gout_a = (run_len >= 9) ? 4'd3 : (run_len >= 5) ? 4'd1 : 4'd0;
                run_len++;
            end
            if (state_a == 3'd3 && !core_en_a && !core_reset_a) chk_len++;
            tick();
        end
        checkOutput(32'(rst_len));
        checkOutput(32'(run_len));
        checkOutput(32'(chk_len));
        checkOutput(32'(cnt_err));
        checkOutput(32'(cycle_cnt_a));
        checkOutput(32'(done_a));
        checkOutput(32'(pass_a));
        checkOutput(32'(trace_cnt_a));
        trace_idx_a = 3'd0; #1;
        checkOutput(32'(trace_data_a));
        trace_idx_a = 3'd1; #1;
        checkOutput(32'(trace_data_a));
        trace_idx_a = 3'd5; #1;
        checkOutput(32'(trace_data_a));
    endtask

    task automatic resetMidRun();
        applyStimulus(1'b0, 4'd3);
        for (int guard = 0; guard < 100; guard++) begin
            if (state_a == 3'd2 && cycle_cnt_a == 16'd7) break;
            if (state_a == 3'd2) gout_a = gout_a + 4'd1;
            tick();
        end
        expectVal("a_pre_reset_trace", 32'd6);
        checkOutput(32'(trace_cnt_a));
        expectVal("a_mid_reset_state", 32'd0);
        expectVal("a_mid_reset_core_reset", 32'd1);
        expectVal("a_mid_reset_core_en", 32'd0);
        expectVal("a_mid_reset_trace", 32'd0);
        expectVal("a_mid_reset_done", 32'd0);
        reset_a = 1'b1;
        tick();
        checkOutput(32'(state_a));
        checkOutput(32'(core_reset_a));
        checkOutput(32'(core_en_a));
        checkOutput(32'(trace_cnt_a));
        checkOutput(32'(done_a));
        reset_a = 1'b0;
        tick();
    endtask

    // Free-run instance: toggle=1 flips gout every run cycle; stop ends the run.
    task automatic runB(input int stop_at, input int start_at, input bit toggle);
        logic [3:0] expv;
        int rst_len = 0;
        int run_len = 0;
        int chk_len = 0;
        int cnt_err = 0;
        int k;
        expv = toggle ? 4'(stop_at & 1) : 4'h5;
        expectVal("b_start_state", 32'd1);
        expectVal("b_rst_len", 32'd2);
        expectVal("b_run_len", 32'(stop_at + 1));
        expectVal("b_chk_len", 32'd1);
        expectVal("b_cnt_track_err", 32'd0);
        expectVal("b_cycle_cnt", 32'(stop_at));
        expectVal("b_done", 32'd1);
        expectVal("b_pass", 32'd1);
        expectVal("b_trace_cnt", toggle ? 32'd4 : 32'd0);
        if (toggle) begin
            for (int i = 0; i < 4; i++) begin
                k = stop_at - 3 + i;
                expectVal($sformatf("b_trace%0d", i), 32'({16'(k), 4'(k & 1)}));
            end
        end else begin
            expectVal("b_trace0_empty", 32'd0);
        end
        applyStimulus(1'b1, expv);
        checkOutput(32'(state_b));
        for (int guard = 0; guard < 400 && !done_b; guard++) begin
            if (state_b == 3'd1 && core_reset_b && !core_en_b) rst_len++;
            if (state_b == 3'd2 && core_en_b && !core_reset_b) begin
                if (32'(cycle_cnt_b) != run_len) cnt_err++;
                gout_b  = toggle ? 4'(run_len & 1) : 4'h5;
                stop_b  = (run_len == stop_at);
                start_b = (run_len == start_at);
                run_len++;
            end else begin
                stop_b  = 1'b0;
                start_b = 1'b0;
            end
            if (state_b == 3'd3 && !core_en_b && !core_reset_b) chk_len++;
            tick();
        end
        stop_b  = 1'b0;
        start_b = 1'b0;
        checkOutput(32'(rst_len));
        checkOutput(32'(run_len));
        checkOutput(32'(chk_len));
        checkOutput(32'(cnt_err));
        checkOutput(32'(cycle_cnt_b));
        checkOutput(32'(done_b));
        checkOutput(32'(pass_b));
        checkOutput(32'(trace_cnt_b));
        for (int i = 0; i < (toggle ? 4 : 1); i++) begin
            trace_idx_b = 2'(i); #1;
            checkOutput(32'(trace_data_b));
        end
    endtask

    initial begin
        tick();
        tick();
        expectVal("a_rst_state", 32'd0);
        expectVal("a_rst_core_reset", 32'd1);
        expectVal("a_rst_core_en", 32'd0);
        expectVal("a_rst_cycle", 32'd0);
        expectVal("a_rst_done", 32'd0);
        expectVal("a_rst_pass", 32'd0);
        expectVal("a_rst_trace", 32'd0);
        expectVal("b_rst_state", 32'd0);
        expectVal("b_rst_trace", 32'd0);
        checkOutput(32'(state_a));
        checkOutput(32'(core_reset_a));
        checkOutput(32'(core_en_a));
        checkOutput(32'(cycle_cnt_a));
        checkOutput(32'(done_a));
        checkOutput(32'(pass_a));
        checkOutput(32'(trace_cnt_a));
        checkOutput(32'(state_b));
        checkOutput(32'(trace_cnt_b));
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        $display("[TB] timed run, expect_gout=3");
        runA(4'd3);
        $display("[TB] restart from DONE, expect_gout=4");
        runA(4'd4);
        $display("[TB] reset during RUN");
        resetMidRun();
        runA(4'd3);

        $display("[TB] free-run instance, depth 4");
        runB(20, -1, 1'b1);
        runB(100, 50, 1'b0);
        runB(22, -1, 1'b1);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("[TB] FAIL leftover_expected: observed %0d queued expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
